pkt_fifo: RTL

PKT_FIFO -- requirements
Module: pkt_fifo

---
 rtl/pkt_fifo.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pkt_fifo.sv
// Store-and-forward packet FIFO: words become readable together when their packet's eop is written; show-ahead read, pop in 1 cycle.
// No write backpressure: a packet that does not fit is dropped whole (overflow sticky, drop_pulse per packet); reads pop on rd_en.
module pkt_fifo #(
  parameter int DATA_WIDTH = 256,
  parameter int PTR_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic                  wr_vld,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic                  rd_sop,
  output logic                  rd_eop,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [PTR_W:0]        word_cnt,
  output logic [PTR_W:0]        pkt_cnt,
  output logic                  pkt_avail,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  drop_pulse
);

  localparam int             DEPTH   = 2**PTR_W;
  localparam logic [PTR_W:0] DEPTH_W = {1'b1, {PTR_W{1'b0}}};
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t         state_q, state_d;
  logic [PTR_W:0] wptr_q, wptr_d;
  logic [PTR_W:0] sptr_q, sptr_d;
  logic [PTR_W:0] rptr_q, rptr_d;
  logic [PTR_W:0] pkt_cnt_q, pkt_cnt_d;
  logic           overflow_q, overflow_d;
  logic           drop_pulse_q, drop_pulse_d;

  entry_t         mem_q [DEPTH];
  entry_t         head;
  logic           mem_we;
  logic [PTR_W:0] base;
  logic [PTR_W:0] base_used;
  logic           commit;
  logic           pop;

  assign head      = mem_q[rptr_q[PTR_W-1:0]];
  assign rd_vld    = (rptr_q != wptr_q);
  assign rd_sop    = head.sop;
  assign rd_eop    = head.eop;
  assign rd_data   = head.data;
  assign word_cnt  = wptr_q - rptr_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign pkt_avail = (pkt_cnt_q != '0);
  assign empty     = (wptr_q == rptr_q);
  assign full      = ((sptr_q - rptr_q) == DEPTH_W);
  assign overflow  = overflow_q;
  assign drop_pulse = drop_pulse_q;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    sptr_d       = sptr_q;
    rptr_d       = rptr_q;
    pkt_cnt_d    = pkt_cnt_q;
    overflow_d   = overflow_q;
    drop_pulse_d = 1'b0;
    mem_we       = 1'b0;
    commit       = 1'b0;
    pop          = rd_en && rd_vld;
    // A sop word always restarts at the committed pointer, abandoning any partial packet.
    base         = wr_sop ? wptr_q : sptr_q;
    base_used    = base - rptr_q;

    if (wr_vld) begin
      if (wr_sop || state_q == RECV) begin
        if (base_used != DEPTH_W) begin
          mem_we = 1'b1;
          sptr_d = base + PTR_ONE;
          if (wr_eop) begin
            wptr_d  = base + PTR_ONE;
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RECV;
          end
        end else begin
          sptr_d     = wptr_q;
          overflow_d = 1'b1;
          if (wr_eop) begin
            drop_pulse_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = DROP;
          end
        end
      end else if (state_q == DROP && wr_eop) begin
        drop_pulse_d = 1'b1;
        state_d      = IDLE;
      end
    end

    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    // Commit and eop-pop in the same edge cancel out.
    if (commit && !(pop && head.eop)) begin
      pkt_cnt_d = pkt_cnt_q + PTR_ONE;
    end else if (!commit && pop && head.eop) begin
      pkt_cnt_d = pkt_cnt_q - PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      sptr_q       <= '0;
      rptr_q       <= '0;
      pkt_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      sptr_q       <= sptr_d;
      rptr_q       <= rptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      overflow_q   <= overflow_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[base[PTR_W-1:0]] <= '{sop: wr_sop, eop: wr_eop, data: wr_data};
    end
  end

endmodule
